// File: rtl/ova_iic_arbiter.sv
// Two-port round-robin arbiter in front of the single OVA SCCB/I2C driver.
// One whole transaction per grant; a BUSY watchdog frees the bus if the driver never completes.
module ova_iic_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned TO_W        = 21
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        m0_wr_req,
    input  logic        m0_rd_req,
    input  logic [15:0] m0_addr,
    input  logic [5:0]  m0_wr_byte_num,
    input  logic [5:0]  m0_rd_byte_num,
    input  logic [7:0]  m0_wr_data,
    output logic        m0_req_new_byte,
    output logic [7:0]  m0_rd_data,
    output logic        m0_rd_vld,
    output logic        m0_done,
    output logic        m0_err,

    input  logic        m1_wr_req,
    input  logic        m1_rd_req,
    input  logic [15:0] m1_addr,
    input  logic [5:0]  m1_wr_byte_num,
    input  logic [5:0]  m1_rd_byte_num,
    input  logic [7:0]  m1_wr_data,
    output logic        m1_req_new_byte,
    output logic [7:0]  m1_rd_data,
    output logic        m1_rd_vld,
    output logic        m1_done,
    output logic        m1_err,

    output logic        o_iic_wr_req,
    output logic        o_iic_rd_req,
    output logic [15:0] o_iic_addr,
    output logic [5:0]  o_iic_wr_byte_num,
    output logic [5:0]  o_iic_rd_byte_num,
    output logic [7:0]  o_iic_wr_data,
    input  logic [7:0]  i_iic_rd_data,
    input  logic        i_iic_rd_byte_vld,
    input  logic        i_iic_work_done,
    input  logic        i_iic_req_new_byte,

    output logic [1:0]  o_grant,
    output logic        o_busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_BUSY    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam bit              WD_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TO_W-1:0] WD_LAST = WD_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

    logic [1:0]      state_q, state_d;
    logic [1:0]      grant_q, grant_d;
    logic            op_wr_q, op_wr_d;
    logic            last_q, last_d;
    logic [TO_W-1:0] wd_q, wd_d;
    logic [1:0]      done_q, done_d;
    logic [1:0]      err_q, err_d;

    logic req0, req1, pick1;
    logic active, in_busy, sel1;

    assign req0  = m0_wr_req | m0_rd_req;
    assign req1  = m1_wr_req | m1_rd_req;
    // last_q holds the index of the previous owner, so a tie goes to the other port
    assign pick1 = req1 & (~req0 | ~last_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op_wr_d = op_wr_q;
        last_d  = last_q;
        wd_d    = wd_q;
        done_d  = '0;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                wd_d = '0;
                if (req0 | req1) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    op_wr_d = pick1 ? m1_wr_req : m0_wr_req;
                    last_d  = pick1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: state_d = S_BUSY;
            S_BUSY: begin
                if (i_iic_work_done) begin
                    done_d  = grant_q;
                    state_d = S_RELEASE;
                end else if (WD_EN && (wd_q == WD_LAST)) begin
                    err_d   = grant_q;
                    state_d = S_RELEASE;
                end else if (WD_EN) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RELEASE: begin
                wd_d    = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            op_wr_q <= 1'b0;
            last_q  <= 1'b1;
            wd_q    <= '0;
            done_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op_wr_q <= op_wr_d;
            last_q  <= last_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign active  = (state_q == S_LAUNCH) | (state_q == S_BUSY);
    assign in_busy = (state_q == S_BUSY);
    assign sel1    = grant_q[1];

    assign o_grant      = active ? grant_q : '0;
    assign o_busy       = (state_q != S_IDLE);
    assign o_iic_wr_req = (state_q == S_LAUNCH) & op_wr_q;
    assign o_iic_rd_req = (state_q == S_LAUNCH) & ~op_wr_q;

    assign o_iic_addr        = active ? (sel1 ? m1_addr : m0_addr) : '0;
    assign o_iic_wr_byte_num = active ? (sel1 ? m1_wr_byte_num : m0_wr_byte_num) : '0;
    assign o_iic_rd_byte_num = active ? (sel1 ? m1_rd_byte_num : m0_rd_byte_num) : '0;
    assign o_iic_wr_data     = active ? (sel1 ? m1_wr_data : m0_wr_data) : '0;

    // Driver handshakes reach only the current owner and only while BUSY
    assign m0_req_new_byte = in_busy & grant_q[0] & i_iic_req_new_byte;
    assign m0_rd_vld       = in_busy & grant_q[0] & i_iic_rd_byte_vld;
    assign m0_rd_data      = (in_busy & grant_q[0]) ? i_iic_rd_data : '0;
    assign m1_req_new_byte = in_busy & grant_q[1] & i_iic_req_new_byte;
    assign m1_rd_vld       = in_busy & grant_q[1] & i_iic_rd_byte_vld;
    assign m1_rd_data      = (in_busy & grant_q[1]) ? i_iic_rd_data : '0;

    assign m0_done = done_q[0];
    assign m1_done = done_q[1];
    assign m0_err  = err_q[0];
    assign m1_err  = err_q[1];

endmodule

// File: tb/tb_ova_iic_arbiter.sv
// Randomized bench for ova_iic_arbiter: the bench plays both requesters and the driver,
// and predicts ownership, launch pulses, routing and completion from a transaction-level model.
module tb_ova_iic_arbiter;

    localparam int unsigned TO = 100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  wr = '0;
    logic [1:0]  rd = '0;
    logic [15:0] addr [2];
    logic [5:0]  wbn [2];
    logic [5:0]  rbn [2];
    logic [7:0]  wd [2];
    logic [7:0]  drv_rd_data = '0;
    logic        drv_vld  = 1'b0;
    logic        drv_nb   = 1'b0;
    logic        drv_done = 1'b0;

    wire        m0_req_new_byte, m0_rd_vld, m0_done, m0_err;
    wire        m1_req_new_byte, m1_rd_vld, m1_done, m1_err;
    wire [7:0]  m0_rd_data, m1_rd_data;
    wire        o_iic_wr_req, o_iic_rd_req, o_busy;
    wire [15:0] o_iic_addr;
    wire [5:0]  o_iic_wr_byte_num, o_iic_rd_byte_num;
    wire [7:0]  o_iic_wr_data;
    wire [1:0]  o_grant;

    wire [1:0]  done_v = {m1_done, m0_done};
    wire [1:0]  err_v  = {m1_err, m0_err};
    wire [1:0]  vld_v  = {m1_rd_vld, m0_rd_vld};
    wire [1:0]  nb_v   = {m1_req_new_byte, m0_req_new_byte};
    wire [15:0] rdd_v  = {m1_rd_data, m0_rd_data};

    ova_iic_arbiter #(.TIMEOUT_CYC(TO), .TO_W(7)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_wr_req(wr[0]), .m0_rd_req(rd[0]), .m0_addr(addr[0]),
        .m0_wr_byte_num(wbn[0]), .m0_rd_byte_num(rbn[0]), .m0_wr_data(wd[0]),
        .m0_req_new_byte(m0_req_new_byte), .m0_rd_data(m0_rd_data), .m0_rd_vld(m0_rd_vld),
        .m0_done(m0_done), .m0_err(m0_err),
        .m1_wr_req(wr[1]), .m1_rd_req(rd[1]), .m1_addr(addr[1]),
        .m1_wr_byte_num(wbn[1]), .m1_rd_byte_num(rbn[1]), .m1_wr_data(wd[1]),
        .m1_req_new_byte(m1_req_new_byte), .m1_rd_data(m1_rd_data), .m1_rd_vld(m1_rd_vld),
        .m1_done(m1_done), .m1_err(m1_err),
        .o_iic_wr_req(o_iic_wr_req), .o_iic_rd_req(o_iic_rd_req), .o_iic_addr(o_iic_addr),
        .o_iic_wr_byte_num(o_iic_wr_byte_num), .o_iic_rd_byte_num(o_iic_rd_byte_num),
        .o_iic_wr_data(o_iic_wr_data), .i_iic_rd_data(drv_rd_data),
        .i_iic_rd_byte_vld(drv_vld), .i_iic_work_done(drv_done),
        .i_iic_req_new_byte(drv_nb), .o_grant(o_grant), .o_busy(o_busy)
    );

    int checks   = 0;
    int failures = 0;
    int last_g   = 1;          // model: index of the previous owner
    logic [7:0] inj_q [$];     // read bytes the driver should deliver first

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        check({tag, "_grant"}, o_grant, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_launch"}, {o_iic_wr_req, o_iic_rd_req}, 0);
        check({tag, "_addr"}, o_iic_addr, 0);
        check({tag, "_bn"}, {o_iic_wr_byte_num, o_iic_rd_byte_num}, 0);
        check({tag, "_wdata"}, o_iic_wr_data, 0);
        check({tag, "_resp"}, {done_v, err_v}, 0);
        check({tag, "_fwd"}, {vld_v, nb_v, rdd_v}, 0);
    endtask

    task automatic raise(input int p, input int op);
        wr[p]   = op[0];
        rd[p]   = op[1];
        addr[p] = 16'($urandom);
        wbn[p]  = 6'($urandom_range(1, 63));
        rbn[p]  = 6'($urandom_range(1, 63));
        wd[p]   = 8'($urandom);
    endtask

    // Called at an IDLE negedge with at least one request present.
    // done_at: BUSY cycle index on which the driver reports completion; <0 or >=TO means never.
    task automatic run_txn(input int done_at, input int exp_w, input bit allow_drop);
        int w, end_n;
        bit exp_wr, timed_out, rv, nv;
        logic [1:0] oh;
        logic [7:0] rdd;
        if ((wr[0] | rd[0]) && (wr[1] | rd[1])) w = 1 - last_g;
        else w = (wr[0] | rd[0]) ? 0 : 1;
        last_g = w;
        exp_wr = wr[w];
        oh = (w == 0) ? 2'b01 : 2'b10;
        timed_out = !(done_at >= 0 && done_at < int'(TO));
        end_n = timed_out ? int'(TO) - 1 : done_at;

        @(negedge clk);
        if (exp_w >= 0) check("order", o_grant, (exp_w == 0) ? 2'b01 : 2'b10);
        check("launch_grant", o_grant, oh);
        check("launch_wr", o_iic_wr_req, exp_wr);
        check("launch_rd", o_iic_rd_req, !exp_wr);
        check("launch_addr", o_iic_addr, addr[w]);
        check("launch_bn", {o_iic_wr_byte_num, o_iic_rd_byte_num}, {wbn[w], rbn[w]});
        check("launch_wdata", o_iic_wr_data, wd[w]);

        for (int n = 0; n <= end_n; n++) begin
            @(negedge clk);
            check("busy_grant", o_grant, oh);
            check("busy_launch", {o_iic_wr_req, o_iic_rd_req}, 0);
            check("busy_resp", {done_v, err_v}, 0);
            check("busy_addr", o_iic_addr, addr[w]);
            if (allow_drop && n == 1 && $urandom_range(0, 3) == 0) begin
                wr[1-w] = 1'b0;
                rd[1-w] = 1'b0;
            end
            if (inj_q.size() > 0) begin
                rv = 1'b1; nv = 1'b0; rdd = inj_q.pop_front();
            end else begin
                rv = 1'($urandom_range(0, 1)); nv = 1'($urandom_range(0, 1)); rdd = 8'($urandom);
            end
            drv_vld = rv; drv_nb = nv; drv_rd_data = rdd;
            if (nv) wd[w] = 8'($urandom);
            drv_done = (n == done_at);
            #1;
            check("fwd_vld", vld_v, rv ? oh : 2'b00);
            check("fwd_nb", nb_v, nv ? oh : 2'b00);
            check("fwd_rdata", rdd_v, (w == 0) ? {8'h00, rdd} : {rdd, 8'h00});
            check("fwd_wdata", o_iic_wr_data, wd[w]);
        end

        @(negedge clk);
        drv_vld = 1'b0; drv_nb = 1'b0; drv_done = 1'b0; drv_rd_data = '0;
        check("rel_done", done_v, timed_out ? 2'b00 : oh);
        check("rel_err", err_v, timed_out ? oh : 2'b00);
        check("rel_grant", o_grant, 0);
        check("rel_busy", o_busy, 1);
        check("rel_addr", o_iic_addr, 0);
        drv_vld = 1'b1; drv_nb = 1'b1;
        #1;
        check("rel_fwd", {vld_v, nb_v}, 0);
        drv_vld = 1'b0; drv_nb = 1'b0;
        wr[w] = 1'b0;
        rd[w] = 1'b0;

        @(negedge clk);
        check("idle_busy", o_busy, 0);
        check("idle_resp", {done_v, err_v}, 0);
        check("idle_grant", o_grant, 0);
    endtask

    initial begin
        int da;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; wbn[p] = '0; rbn[p] = '0; wd[p] = '0;
        end
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_reset");

        // Tie from reset, then strict alternation while both keep requesting
        raise(0, 1); raise(1, 2);
        run_txn(2, 0, 1'b0);
        raise(0, 1);
        run_txn(1, 1, 1'b0);
        raise(1, 2);
        run_txn(3, 0, 1'b0);
        raise(0, 2);
        run_txn(0, 1, 1'b0);
        run_txn(1, 0, 1'b0);

        // Single write
        raise(0, 1); addr[0] = 16'h3012; wbn[0] = 6'd1; wd[0] = 8'h80;
        run_txn(3, 0, 1'b0);

        // Two-byte read on m1
        raise(1, 2); rbn[1] = 6'd2;
        inj_q.push_back(8'h55); inj_q.push_back(8'hAA);
        run_txn(3, 1, 1'b0);

        // Watchdog abort, then the pending m1 is served
        raise(0, 1); raise(1, 1);
        run_txn(-1, 0, 1'b0);
        run_txn(2, 1, 1'b0);

        // Completion on the last watchdog cycle wins; one cycle earlier is ordinary
        raise(0, 2);
        run_txn(int'(TO) - 1, 0, 1'b0);
        raise(1, 1);
        run_txn(int'(TO) - 2, 1, 1'b0);

        // Write and read together: only the write launches
        raise(0, 3);
        run_txn(1, 0, 1'b0);

        // Spurious completion while idle
        drv_done = 1'b1;
        @(negedge clk);
        drv_done = 1'b0;
        chk_quiet("spurious_a");
        @(negedge clk);
        chk_quiet("spurious_b");

        // Reset while m1 is in BUSY, m0 arrives meanwhile
        raise(1, 1);
        repeat (3) @(negedge clk);
        check("pre_rst_busy", o_busy, 1);
        raise(0, 2);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst_async");
        last_g = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet("rst_hold");
        end
        rst_n = 1'b1;
        run_txn(2, 0, 1'b0);
        run_txn(1, 1, 1'b0);

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < 2; p++)
                if (!(wr[p] | rd[p]) && $urandom_range(0, 1) == 1)
                    raise(p, int'($urandom_range(1, 3)));
            if (!(wr[0] | rd[0] | wr[1] | rd[1]))
                raise(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
            da = int'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) da = -1;
            run_txn(da, -1, 1'b1);
        end
        for (int k = 0; k < 2; k++)
            if (wr[0] | rd[0] | wr[1] | rd[1]) run_txn(1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1ms");
        $fatal(1, "simulation time limit");
    end

endmodule
